// File: rtl/npu_host_pkg.sv
// Shared types and constants for the npu host sequencer.
// Phase encoding and config-word ordering live here.
package npu_host_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_CFG,
        S_WGT,
        S_INP,
        S_WAIT,
        S_OUT
    } state_e;

    localparam int NUM_CFG_WORDS = 6;

    localparam logic [2:0] CFG_LAYERS = 3'd0;
    localparam logic [2:0] CFG_IN     = 3'd1;
    localparam logic [2:0] CFG_H1     = 3'd2;
    localparam logic [2:0] CFG_H2     = 3'd3;
    localparam logic [2:0] CFG_OUT    = 3'd4;
    localparam logic [2:0] CFG_ACT    = 3'd5;

endpackage

// File: rtl/npu_host_if.sv
// Job input stream, result output stream and npu bus bundle.
// master is the sequencer side, slave is the host/npu side.
interface npu_host_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              npu_we;
    logic              npu_oe;
    logic [DATA_W-1:0] npu_data_o;
    logic              npu_data_drive;
    logic [DATA_W-1:0] npu_data_i;

    modport master (
        input  in_valid, in_data, out_ready, npu_data_i,
        output in_ready, out_valid, out_data,
        output npu_we, npu_oe, npu_data_o, npu_data_drive
    );

    modport slave (
        output in_valid, in_data, out_ready, npu_data_i,
        input  in_ready, out_valid, out_data,
        input  npu_we, npu_oe, npu_data_o, npu_data_drive
    );
endinterface

// File: rtl/npu_host_out_reg.sv
// One-entry result holding register with valid/ready.
// can_read is high only when the slot is guaranteed empty next cycle.
module npu_host_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              can_read
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q & ~out_ready;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign can_read  = ~valid_d;
endmodule

// File: rtl/npu_host_sequencer.sv
// Host-side job sequencer: lead, config, weights, inputs,
// calc wait, then result readout over the shared npu bus.
module npu_host_sequencer
    import npu_host_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int W_CNT_W = 12,
    parameter int N_CNT_W = 5,
    parameter int WAIT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         cfg_num_layers,
    input  logic [N_CNT_W-1:0] cfg_num_in,
    input  logic [N_CNT_W-1:0] cfg_num_h1,
    input  logic [N_CNT_W-1:0] cfg_num_h2,
    input  logic [N_CNT_W-1:0] cfg_num_out,
    input  logic [1:0]         cfg_act,
    input  logic [W_CNT_W-1:0] cfg_num_w,
    input  logic [WAIT_W-1:0]  cfg_calc_wait,
    output logic               busy,
    output logic               done,
    npu_host_if.master         bus
);
    state_e state_q, state_d;
    logic [W_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         layers_q, layers_d, act_q, act_d;
    logic [N_CNT_W-1:0] num_in_q, num_in_d, num_h1_q, num_h1_d;
    logic [N_CNT_W-1:0] num_h2_q, num_h2_d, num_out_q, num_out_d;
    logic [W_CNT_W-1:0] num_w_q, num_w_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               we_q, we_d, oe_q, oe_d, drive_q, drive_d;
    logic               rdy_q, rdy_d, busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0]  dat_q, dat_d;
    logic [2:0]         cfg_idx;
    logic [DATA_W-1:0]  cfg_word;
    logic               xfer, can_read, ov;
    logic [DATA_W-1:0]  od;

    npu_host_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (oe_q),
        .load_data (bus.npu_data_i),
        .out_ready (bus.out_ready),
        .out_valid (ov),
        .out_data  (od),
        .can_read  (can_read)
    );

    assign xfer    = bus.in_valid & rdy_q;
    assign cfg_idx = (state_q == S_CFG) ? cnt_q[2:0] : CFG_LAYERS;

    always_comb begin
        cfg_word = '0;
        unique case (cfg_idx)
            CFG_LAYERS: cfg_word = DATA_W'(layers_q);
            CFG_IN:     cfg_word = DATA_W'(num_in_q);
            CFG_H1:     cfg_word = DATA_W'(num_h1_q);
            CFG_H2:     cfg_word = DATA_W'(num_h2_q);
            CFG_OUT:    cfg_word = DATA_W'(num_out_q);
            CFG_ACT:    cfg_word = DATA_W'(act_q);
            default:    cfg_word = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        layers_d  = layers_q;
        num_in_d  = num_in_q;
        num_h1_d  = num_h1_q;
        num_h2_d  = num_h2_q;
        num_out_d = num_out_q;
        act_d     = act_q;
        num_w_d   = num_w_q;
        wait_d    = wait_q;
        we_d      = 1'b0;
        oe_d      = 1'b0;
        drive_d   = drive_q;
        rdy_d     = rdy_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dat_d     = dat_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LEAD;
                    busy_d    = 1'b1;
                    we_d      = 1'b1;
                    drive_d   = 1'b1;
                    dat_d     = '0;
                    layers_d  = cfg_num_layers;
                    num_in_d  = cfg_num_in;
                    num_h1_d  = cfg_num_h1;
                    num_h2_d  = cfg_num_h2;
                    num_out_d = cfg_num_out;
                    act_d     = cfg_act;
                    num_w_d   = cfg_num_w;
                    wait_d    = cfg_calc_wait;
                end
            end
            S_LEAD: begin
                state_d = S_CFG;
                we_d    = 1'b1;
                dat_d   = cfg_word;
                cnt_d   = W_CNT_W'(1);
            end
            // ready rises with the last config word so weights follow unbroken
            S_CFG: begin
                we_d  = 1'b1;
                dat_d = cfg_word;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == W_CNT_W'(NUM_CFG_WORDS - 1)) begin
                    rdy_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = (num_w_q == '0) ? S_INP : S_WGT;
                end
            end
            S_WGT: begin
                we_d = xfer;
                if (xfer) begin
                    dat_d = bus.in_data;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == num_w_q - W_CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_INP;
                    end
                end
            end
            S_INP: begin
                we_d = xfer;
                if (xfer) begin
                    dat_d = bus.in_data;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == W_CNT_W'(num_in_q)) begin
                        cnt_d   = '0;
                        rdy_d   = 1'b0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                drive_d = 1'b0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == W_CNT_W'(wait_q)) begin
                    state_d = S_OUT;
                    oe_d    = can_read;
                    cnt_d   = W_CNT_W'(can_read);
                end
            end
            // cnt counts reads issued; finish once the last one drains
            S_OUT: begin
                if (cnt_q <= W_CNT_W'(num_out_q) && can_read) begin
                    oe_d  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end else if (cnt_q > W_CNT_W'(num_out_q) && !oe_q
                             && ov && bus.out_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            layers_q  <= '0;
            num_in_q  <= '0;
            num_h1_q  <= '0;
            num_h2_q  <= '0;
            num_out_q <= '0;
            act_q     <= '0;
            num_w_q   <= '0;
            wait_q    <= '0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            drive_q   <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            layers_q  <= layers_d;
            num_in_q  <= num_in_d;
            num_h1_q  <= num_h1_d;
            num_h2_q  <= num_h2_d;
            num_out_q <= num_out_d;
            act_q     <= act_d;
            num_w_q   <= num_w_d;
            wait_q    <= wait_d;
            we_q      <= we_d;
            oe_q      <= oe_d;
            drive_q   <= drive_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dat_q     <= dat_d;
        end
    end

    assign bus.in_ready       = rdy_q;
    assign bus.out_valid      = ov;
    assign bus.out_data       = od;
    assign bus.npu_we         = we_q;
    assign bus.npu_oe         = oe_q;
    assign bus.npu_data_o     = dat_q;
    assign bus.npu_data_drive = drive_q;
    assign busy               = busy_q;
    assign done               = done_q;
endmodule

// File: tb/tb_npu_host_sequencer.sv
// Directed bench for npu_host_sequencer: scoreboarded bus words,
// responder-generated results, phase timing and reset behaviour.
module tb_npu_host_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [1:0]  cfg_num_layers, cfg_act;
    logic [4:0]  cfg_num_in, cfg_num_h1, cfg_num_h2, cfg_num_out;
    logic [11:0] cfg_num_w;
    logic [7:0]  cfg_calc_wait;

    npu_host_if #(.DATA_W(32)) bus ();

    npu_host_sequencer #(
        .DATA_W(32), .W_CNT_W(12), .N_CNT_W(5), .WAIT_W(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_num_layers (cfg_num_layers),
        .cfg_num_in     (cfg_num_in),
        .cfg_num_h1     (cfg_num_h1),
        .cfg_num_h2     (cfg_num_h2),
        .cfg_num_out    (cfg_num_out),
        .cfg_act        (cfg_act),
        .cfg_num_w      (cfg_num_w),
        .cfg_calc_wait  (cfg_calc_wait),
        .busy           (busy),
        .done           (done),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_we[$];
    logic [31:0] exp_res[$];
    logic [31:0] src_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Source driver: the transfer decided at one negedge pops next negedge
    int dcyc = 0;
    bit bubbles = 1'b0;
    bit xfer_pend = 1'b0;
    always @(negedge clk) begin
        dcyc++;
        if (rst) begin
            src_q.delete();
            xfer_pend = 1'b0;
        end else if (xfer_pend) begin
            void'(src_q.pop_front());
        end
        bus.in_valid = !rst && src_q.size() != 0
                       && !(bubbles && dcyc % 3 == 0);
        bus.in_data  = (src_q.size() != 0) ? src_q[0] : 32'h0;
        xfer_pend    = bus.in_valid && bus.in_ready;
    end

    // Bus monitor, npu read responder and result scoreboard
    int cyc = 0;
    int we_cnt, we_runs, oe_cnt, res_cnt, done_cnt;
    int last_we_cyc, first_oe_cyc, acc_cyc, done_cyc, rd_idx;
    bit prev_we = 1'b0;
    logic [31:0] rbase = 32'h0;
    always @(negedge clk) begin
        cyc++;
        if (bus.npu_we === 1'b1) begin
            we_cnt++;
            if (!prev_we) we_runs++;
            last_we_cyc = cyc;
            check("we_drive", 32'(bus.npu_data_drive), 32'd1);
            check("we_oe_excl", 32'(bus.npu_oe), 32'd0);
            checks++;
            assert (exp_we.size() != 0) else begin
                errors++;
                $error("FAIL we_extra: got %0h want no write",
                       bus.npu_data_o);
            end
            if (exp_we.size() != 0)
                check("we_word", bus.npu_data_o, exp_we.pop_front());
        end
        prev_we = (bus.npu_we === 1'b1);
        if (bus.npu_oe === 1'b1) begin
            oe_cnt++;
            if (first_oe_cyc < 0) first_oe_cyc = cyc;
            check("oe_drive", 32'(bus.npu_data_drive), 32'd0);
            bus.npu_data_i = rbase + 32'(rd_idx);
            rd_idx++;
        end else begin
            bus.npu_data_i = 32'hDEAD_0000 | 32'(cyc[15:0]);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0)
            check("oe_stall", 32'(bus.npu_oe), 32'd0);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            res_cnt++;
            acc_cyc = cyc;
            checks++;
            assert (exp_res.size() != 0) else begin
                errors++;
                $error("FAIL res_extra: got %0h want none", bus.out_data);
            end
            if (exp_res.size() != 0)
                check("result", bus.out_data, exp_res.pop_front());
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_stats();
        we_cnt = 0; we_runs = 0; oe_cnt = 0; res_cnt = 0; done_cnt = 0;
        last_we_cyc = 0; first_oe_cyc = -1; acc_cyc = 0; done_cyc = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_we"}, 32'(bus.npu_we), 32'd0);
        check({tag, "_oe"}, 32'(bus.npu_oe), 32'd0);
        check({tag, "_drive"}, 32'(bus.npu_data_drive), 32'd0);
        check({tag, "_data_o"}, bus.npu_data_o, 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"}, bus.out_data, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic launch(input int ly, input int ni, input int h1,
                          input int h2, input int no, input int ac,
                          input int nw, input int cw, input int tag);
        logic [31:0] w;
        cfg_num_layers = 2'(ly);
        cfg_num_in     = 5'(ni);
        cfg_num_h1     = 5'(h1);
        cfg_num_h2     = 5'(h2);
        cfg_num_out    = 5'(no);
        cfg_act        = 2'(ac);
        cfg_num_w      = 12'(nw);
        cfg_calc_wait  = 8'(cw);
        clear_stats();
        exp_we.push_back(32'd0);
        exp_we.push_back(32'(ly));
        exp_we.push_back(32'(ni));
        exp_we.push_back(32'(h1));
        exp_we.push_back(32'(h2));
        exp_we.push_back(32'(no));
        exp_we.push_back(32'(ac));
        for (int i = 0; i < nw; i++) begin
            w = 32'h1000_0000 + (32'(tag) << 16) + 32'(i);
            exp_we.push_back(w);
            src_q.push_back(w);
        end
        for (int i = 0; i <= ni; i++) begin
            w = 32'h2000_0000 + (32'(tag) << 16) + 32'(i);
            exp_we.push_back(w);
            src_q.push_back(w);
        end
        rbase  = 32'h3000_0000 + (32'(tag) << 16);
        rd_idx = 0;
        for (int k = 0; k <= no; k++) exp_res.push_back(rbase + 32'(k));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_num_layers = 2'($urandom);
        cfg_num_in     = 5'($urandom);
        cfg_num_h1     = 5'($urandom);
        cfg_num_h2     = 5'($urandom);
        cfg_num_out    = 5'($urandom);
        cfg_act        = 2'($urandom);
        cfg_num_w      = 12'($urandom_range(0, 4095));
        cfg_calc_wait  = 8'($urandom);
    endtask

    task automatic finish_job(input string tag, input int n_we,
                              input int n_out, input int cw,
                              input int runs);
        int n = 0;
        while (done_cnt == 0 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'(n_we));
        if (runs > 0) check({tag, "_we_runs"}, 32'(we_runs), 32'(runs));
        check({tag, "_oe_cnt"}, 32'(oe_cnt), 32'(n_out));
        check({tag, "_res_cnt"}, 32'(res_cnt), 32'(n_out));
        check({tag, "_gap"}, 32'(first_oe_cyc - last_we_cyc - 1), 32'(cw));
        check({tag, "_done_lat"}, 32'(done_cyc - acc_cyc), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_we_left"}, 32'(exp_we.size()), 32'd0);
        check({tag, "_res_left"}, 32'(exp_res.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b1;
        cfg_num_layers = '0; cfg_num_in = '0; cfg_num_h1 = '0;
        cfg_num_h2 = '0; cfg_num_out = '0; cfg_act = '0;
        cfg_num_w = '0; cfg_calc_wait = '0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // hotspot job, continuous stream
        launch(0, 25, 0, 0, 0, 0, 27, 5, 1);
        check("j1_busy", 32'(busy), 32'd1);
        finish_job("j1", 60, 1, 5, 1);

        // same job with a bubble every third cycle
        bubbles = 1'b1;
        launch(0, 25, 0, 0, 0, 0, 27, 5, 2);
        finish_job("j2", 60, 1, 5, 0);
        check("j2_bubbles", 32'(we_runs > 1), 32'd1);
        bubbles = 1'b0;

        // four results with downstream stall after the first
        bus.out_ready = 1'b0;
        launch(2, 3, 4, 2, 3, 1, 10, 2, 3);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        finish_job("j3", 21, 4, 2, 1);

        // reset in the middle of the weight phase
        launch(1, 4, 3, 0, 2, 2, 20, 3, 4);
        n = 0;
        while (we_cnt < 17 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("midrst");
        exp_we.delete();
        exp_res.delete();
        rst = 1'b0;
        clear_stats();
        repeat (5) @(posedge clk);
        #1;
        check("quiet_we", 32'(we_cnt), 32'd0);
        check("quiet_oe", 32'(oe_cnt), 32'd0);
        launch(1, 4, 3, 0, 2, 2, 20, 3, 5);
        finish_job("j5", 32, 3, 3, 1);

        // start pulsed during the input phase is ignored
        launch(0, 7, 1, 1, 1, 3, 5, 4, 6);
        n = 0;
        while (we_cnt < 14 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        cfg_num_w  = 12'd0;
        cfg_num_in = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_job("j6", 20, 2, 4, 1);

        // zero-weight job
        launch(3, 4, 9, 8, 0, 1, 0, 1, 7);
        finish_job("j7", 12, 1, 1, 1);

        // zero calc wait
        launch(0, 2, 0, 0, 0, 0, 3, 0, 8);
        finish_job("j8", 13, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
